// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampling with an internal
// baud-tick divider. Emits each framed byte with a one-clock rx_done strobe;
// frame_err reports a low stop bit and holds until the next rx_done.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16            // only 16 is supported
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    // Clocks per oversample tick (truncating division), derived only.
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [2:0]    b_cnt_q, b_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          fall_edge;
    logic          tick;

    // Two-flop synchronizer plus a previous-sample flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_edge = !rx_s_q && rx_prev_q;
    // The divider is parked at zero in IDLE, so gate the tick as well.
    assign tick      = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            s_cnt_q    <= '0;
            b_cnt_q    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            s_cnt_q    <= s_cnt_d;
            b_cnt_q    <= b_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic: tick divider, bit/tick counters, sampling and framing.
    always_comb begin
        state_d  = state_q;
        s_cnt_d  = s_cnt_q;
        b_cnt_d  = b_cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ferr_d   = ferr_q;

        if (state_q == IDLE || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Only a falling edge arms the receiver; a stuck-low line cannot.
                if (fall_edge) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == 4'd7) begin
                        // Middle of the start bit: still low means a real frame.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        s_cnt_d = '0;
                        if (b_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            b_cnt_d = b_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == 4'd15) begin
                        // Finish at mid-stop so a back-to-back start edge is caught.
                        done_d  = 1'b1;
                        state_d = IDLE;
                        s_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d = shift_q;
                            ferr_d = 1'b0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
